// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - parameterised SPI master with runtime mode, bit order and divider
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  hcnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;
  logic              lsb_q;
  logic [EW-1:0]     edge_cnt;
  logic              leading;
  logic              half_end;

  // The edge about to be made is odd-numbered (leading) when an even count has been made so far.
  assign leading  = ~edge_cnt[0];
  assign half_end = (hcnt == div_q);

  function automatic logic head(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_W'(i)) v[i] = 1'b0;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_q    <= '0;
      hcnt     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      edge_cnt <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          if (start) begin
            state    <= S_SETUP;
            busy     <= 1'b1;
            cs_n     <= cs_decode(cs_sel);
            div_q    <= clk_div;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            hcnt     <= '0;
            edge_cnt <= '0;
            // CPHA=0 presents the first bit before any edge; CPHA=1 waits for edge 1.
            if (cpha) begin
              tx_sh <= tx_data;
            end else begin
              mosi  <= head(tx_data, lsb_first);
              tx_sh <= shift(tx_data, lsb_first);
            end
          end
        end
        S_SETUP: begin
          if (half_end) begin
            hcnt  <= '0;
            state <= S_XFER;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_XFER: begin
          if (half_end) begin
            hcnt     <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + 1'b1;
            if (leading != cpha_q)
              rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
            if ((cpha_q && leading) || (!cpha_q && !leading && edge_cnt != LAST_EDGE)) begin
              mosi  <= head(tx_sh, lsb_q);
              tx_sh <= shift(tx_sh, lsb_q);
            end
            if (edge_cnt == LAST_EDGE) state <= S_HOLD;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (half_end) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            cs_n    <= '1;
            mosi    <= 1'b0;
            rx_data <= rx_sh;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - randomized self-checking bench for spi_master_cfg
module tb_spi_master_cfg;
  localparam int DATA_W = 8;
  localparam int NUM_CS = 5;
  localparam int DIV_W  = 8;
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [CS_W-1:0]   cs_sel = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              lsb_first = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              miso = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master_cfg #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .rx_data(rx_data), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
    .miso(miso), .cs_n(cs_n)
  );

  // Number of sclk edges already visible in cycle n of a transfer with half-period h.
  function automatic int edges_at(int n, int h);
    int k;
    if (n < 1) return 0;
    k = (n - 1) / h - 1;
    if (k < 0) k = 0;
    if (k > 2 * DATA_W) k = 2 * DATA_W;
    return k;
  endfunction

  function automatic logic bit_of(logic [DATA_W-1:0] w, int j, logic lsb);
    return lsb ? w[j] : w[DATA_W-1-j];
  endfunction

  function automatic logic [NUM_CS-1:0] exp_cs(int sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    if (sel < NUM_CS) v[sel] = 1'b0;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] rev(logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
    return r;
  endfunction

  task automatic run_xfer(input logic [DATA_W-1:0] tx, input int sel, input logic pol,
                          input logic pha, input logic lsb, input int div,
                          input logic [DATA_W-1:0] slave, input bit scramble,
                          input bit start_in_done, input string tag);
    int h, t, e, sd, edges_seen, dones;
    logic prev_sclk, exp_sclk, exp_mosi, exp_busy;
    logic [DATA_W-1:0] exp_rx;
    logic [NUM_CS-1:0] exp_csn;
    h = div + 1;
    t = 1 + (2 * DATA_W + 2) * h;
    exp_rx = lsb ? rev(slave) : slave;
    @(negedge clk);
    start = 1'b1; tx_data = tx; cs_sel = CS_W'(sel); cpol = pol; cpha = pha;
    lsb_first = lsb; clk_div = DIV_W'(div);
    prev_sclk = pol; edges_seen = 0; dones = 0;
    for (int n = 1; n <= t; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        start = 1'($urandom); tx_data = DATA_W'($urandom); cs_sel = CS_W'($urandom);
        cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
        clk_div = DIV_W'($urandom);
      end
      if (n == t) start = start_in_done;
      e = edges_at(n, h);
      exp_busy = (n <= (2 * DATA_W + 2) * h);
      exp_sclk = pol ^ e[0];
      if (!exp_busy) exp_mosi = 1'b0;
      else if (!pha) exp_mosi = bit_of(tx, (e / 2 < DATA_W) ? e / 2 : DATA_W - 1, lsb);
      else exp_mosi = (e == 0) ? 1'b0 : bit_of(tx, (e - 1) / 2, lsb);
      exp_csn = exp_busy ? exp_cs(sel) : '1;
      sd = pha ? e / 2 : (e + 1) / 2;
      miso = (sd < DATA_W) ? slave[DATA_W-1-sd] : 1'b0;
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL %s busy cyc=%0d got %b exp %b", tag, n, busy, exp_busy);
      end
      n_checks++;
      if (done !== (n == t)) begin
        n_fail++; $display("FAIL %s done cyc=%0d got %b exp %b", tag, n, done, (n == t));
      end
      n_checks++;
      if (sclk !== exp_sclk) begin
        n_fail++; $display("FAIL %s sclk cyc=%0d got %b exp %b", tag, n, sclk, exp_sclk);
      end
      n_checks++;
      if (mosi !== exp_mosi) begin
        n_fail++; $display("FAIL %s mosi cyc=%0d got %b exp %b", tag, n, mosi, exp_mosi);
      end
      n_checks++;
      if (cs_n !== exp_csn) begin
        n_fail++; $display("FAIL %s cs_n cyc=%0d got %b exp %b", tag, n, cs_n, exp_csn);
      end
      if (n == t) begin
        n_checks++;
        if (rx_data !== exp_rx) begin
          n_fail++; $display("FAIL %s rx_data got %h exp %h", tag, rx_data, exp_rx);
        end
      end
      if (sclk !== prev_sclk) edges_seen++;
      prev_sclk = sclk;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (edges_seen != 2 * DATA_W) begin
      n_fail++; $display("FAIL %s edge_count got %0d exp %0d", tag, edges_seen, 2 * DATA_W);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL %s done_count got %0d exp 1", tag, dones);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL reset rx_data got %h exp 0", rx_data); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", done); end
    n_checks++;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL reset sclk got %b exp 0", sclk); end
    n_checks++;
    if (mosi !== 1'b0) begin n_fail++; $display("FAIL reset mosi got %b exp 0", mosi); end
    n_checks++;
    if (cs_n !== '1) begin n_fail++; $display("FAIL reset cs_n got %b exp all ones", cs_n); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_sclk();
    @(negedge clk);
    cpol = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sclk !== 1'b1) begin n_fail++; $display("FAIL idle_sclk_hi got %b exp 1", sclk); end
    cpol = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL idle_sclk_lo got %b exp 0", sclk); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_start_ignored();
    run_xfer(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1, 8'hC3, 1'b1, 1'b1, "ignore");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done busy got %b exp 0", busy); end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_done_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; tx_data = 8'hE7; cs_sel = 3'd0; cpol = 1'b1; cpha = 1'b0;
    lsb_first = 1'b0; clk_div = 8'd1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cs_n !== '1) begin n_fail++; $display("FAIL mid_reset cs_n got %b exp all ones", cs_n); end
    n_checks++;
    if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_reset sclk got %b exp 0", sclk); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset busy got %b exp 0", busy); end
    n_checks++;
    if (rx_data !== '0) begin n_fail++; $display("FAIL mid_reset rx_data got %h exp 0", rx_data); end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset done got %b exp 0", done); end
    end
    rst_n = 1'b1;
    run_xfer(8'h3D, 4, 1'b0, 1'b1, 1'b0, 2, 8'h96, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      run_xfer(DATA_W'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               1'($urandom), int'($urandom_range(0, 3)), DATA_W'($urandom), 1'b1, 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_idle_sclk();
    run_xfer(8'hA5, 2, 1'b0, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 1'b0, "mode0");
    run_xfer(8'h81, 1, 1'b1, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b0, "mode3_lsb");
    run_xfer(8'h6B, 0, 1'b0, 1'b0, 1'b0, 0, 8'hD2, 1'b0, 1'b0, "b2b_first");
    run_xfer(8'h19, 3, 1'b0, 1'b1, 1'b0, 0, 8'h4E, 1'b0, 1'b0, "b2b_second");
    test_start_ignored();
    test_reset_mid();
    run_xfer(8'hC9, 5, 1'b0, 1'b0, 1'b0, 1, 8'h77, 1'b0, 1'b0, "dummy_cs");
    test_random();
    run_xfer(8'hB4, 4, 1'b1, 1'b0, 1'b1, 255, 8'h2F, 1'b0, 1'b0, "max_div");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
